// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared state encodings for the CPU clock-enable controller.
package clk_ctrl_pkg;

    localparam logic [1:0] ST_HALT    = 2'b00;
    localparam logic [1:0] ST_RUN     = 2'b01;
    localparam logic [1:0] ST_STEP    = 2'b10;
    localparam logic [1:0] ST_STOPPED = 2'b11;

    typedef enum logic [1:0] {
        HALT    = ST_HALT,
        RUN     = ST_RUN,
        STEP    = ST_STEP,
        STOPPED = ST_STOPPED
    } ctrl_state_t;

endpackage

// File: rtl/cpu_clock_ctrl_debounce.sv
// STEP button conditioner: 2-FF synchroniser, stability counter, accepted level and press pulse.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          meta_r;
    logic          sync_r;
    logic          level_r;
    logic          press_r;
    logic [CW-1:0] cnt_r;

    // Synchronise, then accept a new level only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r  <= 1'b0;
            sync_r  <= 1'b0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            meta_r <= btn_in;
            sync_r <= meta_r;
            if (sync_r != level_r) begin
                if (cnt_r == LAST) begin
                    level_r <= sync_r;
                    press_r <= sync_r;
                    cnt_r   <= '0;
                end else begin
                    press_r <= 1'b0;
                    cnt_r   <= cnt_r + CW'(1);
                end
            end else begin
                press_r <= 1'b0;
                cnt_r   <= '0;
            end
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Turns the divided slow clock into a one-cycle CPU clock enable under RUN/STEP/HLT control.
module cpu_clock_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick_in,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             cpu_halt,
    output logic             cpu_ce,
    output logic [1:0]       state_o,
    output logic             halted,
    output logic [CNT_W-1:0] ce_count
);

    logic             run_meta_r;
    logic             run_s_r;
    logic             tick_q_r;
    logic             tick_rise_s;
    logic             step_level_s;
    logic             step_pulse_s;
    logic             step_press_s;
    ctrl_state_t      state_r;
    ctrl_state_t      next_state_s;
    logic             ce_next_s;
    logic             cpu_ce_r;
    logic             halted_r;
    logic [CNT_W-1:0] ce_count_r;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_in  (step_btn),
        .level   (step_level_s),
        .press   (step_pulse_s)
    );

    // A press is only honoured while the accepted level agrees with it
    assign step_press_s = step_pulse_s & step_level_s;
    assign tick_rise_s  = tick_in & ~tick_q_r;

    // Next-state and enable decision; mode changes take priority over a coincident tick
    always_comb begin
        next_state_s = state_r;
        ce_next_s    = 1'b0;
        case (state_r)
            HALT: begin
                if (run_s_r) begin
                    next_state_s = RUN;
                end else if (step_press_s) begin
                    next_state_s = STEP;
                end else begin
                    next_state_s = HALT;
                end
            end
            RUN: begin
                if (!run_s_r) begin
                    next_state_s = HALT;
                end else if (cpu_halt) begin
                    next_state_s = STOPPED;
                end else if (tick_rise_s) begin
                    ce_next_s = 1'b1;
                end else begin
                    next_state_s = RUN;
                end
            end
            STEP: begin
                if (cpu_halt) begin
                    next_state_s = STOPPED;
                end else if (tick_rise_s) begin
                    ce_next_s    = 1'b1;
                    next_state_s = HALT;
                end else begin
                    next_state_s = STEP;
                end
            end
            STOPPED: begin
                if (!run_s_r) begin
                    next_state_s = HALT;
                end else begin
                    next_state_s = STOPPED;
                end
            end
            default: begin
                next_state_s = HALT;
            end
        endcase
    end

    // Synchronisers, tick history, state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_meta_r <= 1'b0;
            run_s_r    <= 1'b0;
            tick_q_r   <= 1'b0;
            state_r    <= HALT;
            cpu_ce_r   <= 1'b0;
            halted_r   <= 1'b0;
            ce_count_r <= '0;
        end else begin
            run_meta_r <= run_sw;
            run_s_r    <= run_meta_r;
            tick_q_r   <= tick_in;
            state_r    <= next_state_s;
            cpu_ce_r   <= ce_next_s;
            halted_r   <= (next_state_s == STOPPED);
            if (ce_next_s) begin
                ce_count_r <= ce_count_r + CNT_W'(1);
            end else begin
                ce_count_r <= ce_count_r;
            end
        end
    end

    assign cpu_ce   = cpu_ce_r;
    assign state_o  = state_r;
    assign halted   = halted_r;
    assign ce_count = ce_count_r;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Scoreboard bench: stimulus queues the expected ce_count for every pulse it expects; a negedge monitor checks pulses.
module tb_cpu_clock_ctrl;

    localparam int DEB = 4;
    localparam int CW  = 4;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic          tick_in  = 1'b0;
    logic          run_sw   = 1'b0;
    logic          step_btn = 1'b0;
    logic          cpu_halt = 1'b0;
    logic          cpu_ce;
    logic [1:0]    state_o;
    logic          halted;
    logic [CW-1:0] ce_count;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW-1:0] exp_count = '0;
    logic [CW-1:0] sb_q[$];

    cpu_clock_ctrl #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick_in  (tick_in),
        .run_sw   (run_sw),
        .step_btn (step_btn),
        .cpu_halt (cpu_halt),
        .cpu_ce   (cpu_ce),
        .state_o  (state_o),
        .halted   (halted),
        .ce_count (ce_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic t);
        @(posedge clk);
        #1;
        tick_in = t;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0);
    endtask

    // Divide-by-6 tick stream; the first npulses rises are expected to produce a pulse
    task automatic run_ticks(input int n, input int npulses);
        int rises;
        rises = 0;
        for (int i = 0; i < n; i++) begin
            logic t;
            t = ((i % 6) >= 3);
            if (t && !tick_in) begin
                if (rises < npulses) begin
                    exp_count = exp_count + 4'd1;
                    sb_q.push_back(exp_count);
                end
                rises++;
            end
            cyc(t);
        end
    endtask

    task automatic do_reset();
        check("sb_drained", sb_q.size(), 0);
        sb_q.delete();
        @(posedge clk);
        #2;
        reset_n   = 1'b0;
        tick_in   = 1'b0;
        run_sw    = 1'b0;
        step_btn  = 1'b0;
        cpu_halt  = 1'b0;
        exp_count = '0;
        @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    logic t1_r = 1'b0;
    logic t2_r = 1'b0;
    logic prev_ce_r = 1'b0;

    // Monitor: every cpu_ce must follow a tick rise, be single-cycle and match the queued count
    always @(negedge clk) begin
        if (!reset_n) begin
            t1_r      <= 1'b0;
            t2_r      <= 1'b0;
            prev_ce_r <= 1'b0;
        end else begin
            if (cpu_ce) begin
                check("ce_after_rise", int'({t1_r, t2_r}), 2);
                check("ce_single_cycle", int'(prev_ce_r), 0);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got cpu_ce=1 ce_count=%0d expected no pulse", ce_count);
                end else begin
                    check("ce_count_at_pulse", int'(ce_count), int'(sb_q.pop_front()));
                end
            end
            t2_r      <= t1_r;
            t1_r      <= tick_in;
            prev_ce_r <= cpu_ce;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end

    initial begin
        #1;
        check("rst_state", state_o, 0);
        check("rst_ce", cpu_ce, 0);
        check("rst_halted", halted, 0);
        check("rst_count", ce_count, 0);
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;

        // Run with ticks, then reset while a pulse is on the output
        run_sw = 1'b1;
        idle(4);
        check("run_entered", state_o, 1);
        run_ticks(20, 3);
        cyc(1'b1);
        @(posedge clk);
        #2;
        check("pre_reset_ce", cpu_ce, 1);
        reset_n = 1'b0;
        tick_in = 1'b0;
        run_sw  = 1'b0;
        #1;
        check("midreset_ce", cpu_ce, 0);
        check("midreset_state", state_o, 0);
        check("midreset_halted", halted, 0);
        check("midreset_count", ce_count, 0);
        check("sb_before_reset", sb_q.size(), 0);
        exp_count = '0;
        @(posedge clk);
        #3;
        reset_n = 1'b1;

        // Continuous run: 10 ticks in 60 cycles
        run_sw = 1'b1;
        idle(4);
        run_ticks(60, 10);
        idle(3);
        check("run_pulses_left", sb_q.size(), 0);
        check("run_count", ce_count, 10);
        run_sw = 1'b0;
        idle(4);
        check("run_exit_state", state_o, 0);

        // 2-cycle glitch on STEP: no press
        step_btn = 1'b1;
        idle(2);
        step_btn = 1'b0;
        run_ticks(18, 0);
        check("glitch_state", state_o, 0);

        // Clean press: one pulse then back to HALT
        do_reset();
        step_btn = 1'b1;
        idle(10);
        check("step_state", state_o, 2);
        step_btn = 1'b0;
        run_ticks(12, 1);
        idle(2);
        check("step_done_state", state_o, 0);
        check("step_count", ce_count, 1);

        // HLT stops the CPU while RUN stays on
        run_sw = 1'b1;
        idle(4);
        check("hlt_pre_state", state_o, 1);
        cpu_halt = 1'b1;
        idle(1);
        check("hlt_state", state_o, 3);
        check("hlt_halted", halted, 1);
        run_ticks(180, 0);
        check("hlt_hold_state", state_o, 3);
        check("hlt_hold_halted", halted, 1);
        check("hlt_count", ce_count, 1);
        run_sw = 1'b0;
        idle(2);
        check("hlt_sync_latency", state_o, 3);
        idle(1);
        check("hlt_exit_state", state_o, 0);
        check("hlt_exit_halted", halted, 0);
        cpu_halt = 1'b0;

        // run_s falls in the same cycle as a tick rise: no pulse
        run_sw = 1'b1;
        idle(4);
        run_sw = 1'b0;
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b0);
        check("simul_state", state_o, 0);
        check("simul_count", ce_count, 1);

        // STEP press during RUN is ignored
        run_sw = 1'b1;
        idle(4);
        step_btn = 1'b1;
        idle(10);
        step_btn = 1'b0;
        check("press_in_run_state", state_o, 1);
        run_ticks(12, 2);
        idle(2);
        check("press_in_run_count", ce_count, 3);
        run_sw = 1'b0;
        idle(14);
        check("press_not_queued", state_o, 0);

        // Counter wrap with a 4-bit counter: 17 pulses leave 1
        do_reset();
        run_sw = 1'b1;
        idle(4);
        run_ticks(102, 17);
        idle(3);
        check("wrap_count", ce_count, 1);
        check("wrap_pulses_left", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
